// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration blocks.
// Holds the FSM state encoding, byte/frame constants and a counter-width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

   localparam int BYTE_W     = 8;
   localparam int FRAME_BITS = 10;

   // Width able to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_w(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// searching upward modulo N_REQ. Stateless so it can be shared by other arbiters.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] win_oh_o,
   output logic [IW-1:0]    win_idx_o,
   output logic             any_req_o
);

   logic found;
   int   j;

   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req_i[j]) begin
            found       = 1'b1;
            win_oh_o[j] = 1'b1;
            win_idx_o   = IW'(j);
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ clients: round-robin grant, frame
// launch, completion tracking with timeout, and an inter-frame guard gap in baud ticks.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int GAP_BITS      = 2,
   parameter int TIMEOUT_TICKS = 16
) (
   input  logic                      clk_in,
   input  logic                      rst,
   input  logic                      baud_tick,
   input  logic [N_REQ-1:0]          req,
   input  logic [BYTE_W*N_REQ-1:0]   data_in,
   output logic [N_REQ-1:0]          gnt,
   output logic                      tx_start,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      tx_busy,
   input  logic                      tx_done,
   output logic [2:0]                owner,
   output logic                      active,
   output logic                      err_timeout,
   output logic [1:0]                state_dbg
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = cnt_w(TIMEOUT_TICKS);
   localparam int GW = cnt_w(GAP_BITS);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
   localparam logic [GW-1:0] GAP_LD  = GW'(GAP_BITS);

   state_e            state_q;
   logic [N_REQ-1:0]  gnt_q;
   logic              tx_start_q;
   logic [BYTE_W-1:0] tx_data_q;
   logic [2:0]        owner_q;
   logic              active_q;
   logic              err_q;
   logic [IW-1:0]     ptr_q;
   logic [TW-1:0]     tick_cnt_q;
   logic [GW-1:0]     gap_cnt_q;

   logic [N_REQ-1:0]  win_oh;
   logic [IW-1:0]     win_idx;
   logic              any_req;
   logic [IW-1:0]     ptr_d;
   logic [BYTE_W-1:0] tx_data_d;
   logic              timeout_hit;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .any_req_o (any_req)
   );

   always_comb begin
      tx_data_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_oh[i]) tx_data_d = tx_data_d | data_in[BYTE_W*i +: BYTE_W];
      end
   end

   assign ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   // The tick that would make tick_cnt reach TIMEOUT_TICKS; tx_done still takes priority.
   assign timeout_hit = baud_tick && (tick_cnt_q == TO_LAST);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         owner_q    <= '0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
         ptr_q      <= '0;
         tick_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         gnt_q      <= '0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req && !tx_busy) begin
                  gnt_q      <= win_oh;
                  tx_start_q <= 1'b1;
                  tx_data_q  <= tx_data_d;
                  owner_q    <= 3'(win_idx);
                  ptr_q      <= ptr_d;
                  tick_cnt_q <= '0;
                  active_q   <= 1'b1;
                  state_q    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tx_done || timeout_hit) begin
                  err_q <= !tx_done;
                  if (GAP_BITS == 0) begin
                     active_q <= 1'b0;
                     state_q  <= ST_IDLE;
                  end else begin
                     gap_cnt_q <= GAP_LD;
                     state_q   <= ST_GAP;
                  end
               end else if (baud_tick) begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
            ST_GAP: begin
               if (baud_tick) begin
                  if (gap_cnt_q <= GW'(1)) begin
                     gap_cnt_q <= '0;
                     active_q  <= 1'b0;
                     state_q   <= ST_IDLE;
                  end else begin
                     gap_cnt_q <= gap_cnt_q - 1'b1;
                  end
               end
            end
            default: begin
               active_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign owner       = owner_q;
   assign active      = active_q;
   assign err_timeout = err_q;
   assign state_dbg   = state_q;

endmodule
